// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit common-anode 7-segment driver.
// Shadow-captured nibbles, registered outputs, leading-zero and ghost blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int HEX_EN       = 0,
  parameter int LZB_EN       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PLAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PBLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] ILAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_d;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    wrap_q;

  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_dp;
  logic                    lead;
  logic                    lit;
  logic                    wrap;
  logic                    frame_evt;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] r;
    r = 7'h7F;
    case (n)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      default: r = 7'h7F;
    endcase
    if (HEX_EN != 0) begin
      case (n)
        4'hA: r = 7'h08;
        4'hB: r = 7'h03;
        4'hC: r = 7'h46;
        4'hD: r = 7'h21;
        4'hE: r = 7'h06;
        4'hF: r = 7'h0E;
        default: ;
      endcase
    end
    return r;
  endfunction

  // Blank a digit when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead     = lead && (sh_d[4*i +: 4] == 4'h0);
      blank[i] = (LZB_EN != 0) && (i != 0) && lead;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = sh_d[4*i +: 4];
        cur_blank = blank[i];
        cur_dp    = sh_dp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    lit       = (BLANK_CYCLES == 0) || (presc >= PBLANK);
    wrap      = enable && (presc == PLAST);
    frame_evt = wrap && (idx == ILAST);
    seg_next  = {~cur_dp, cur_blank ? 7'h7F : dec(cur_nib)};
    an_next   = (enable && lit) ? ~onehot : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      sh_d        <= '0;
      sh_dp       <= '0;
      wrap_q      <= 1'b0;
      seg_n       <= 8'hFF;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        sh_d  <= din;
        sh_dp <= dp_in;
      end
      if (wrap) begin
        presc <= '0;
        idx   <= (idx == ILAST) ? '0 : idx + 1'b1;
      end else if (enable) begin
        presc <= presc + 1'b1;
      end
      seg_n       <= seg_next;
      an_n        <= an_next;
      // Delayed so the pulse lines up with the first output cycle of digit 0.
      wrap_q      <= frame_evt;
      frame_start <= wrap_q;
    end
  end

endmodule
